// File: rtl/gp_engine_pkg.sv
// -----------------------------------------------------------------------------
// gp_engine_pkg
// Shared types for the GP engine command sequencer.
//   cmd_op_e      : opcode carried in bits [1:0] of a command's address word
//   seq_state_e   : sequencer FSM states (also exported on the debug port)
//   CMD_BUF_DEPTH : number of words in the command buffer
// -----------------------------------------------------------------------------
package gp_engine_pkg;

  localparam int CMD_BUF_DEPTH = 256;

  typedef enum logic [1:0] {
    OP_NOP   = 2'b00,
    OP_WRITE = 2'b01,
    OP_READ  = 2'b10,
    OP_STOP  = 2'b11
  } cmd_op_e;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_FETCH_A  = 3'd1,
    S_FETCH_D  = 3'd2,
    S_DECODE   = 3'd3,
    S_ISSUE    = 3'd4,
    S_WAIT_RSP = 3'd5,
    S_NEXT     = 3'd6,
    S_END      = 3'd7
  } seq_state_e;

endpackage

// File: rtl/gp_cmd_sequencer.sv
// -----------------------------------------------------------------------------
// gp_cmd_sequencer
// Walks the command buffer two words at a time (address word, data word) and
// issues each WRITE/READ command as one single-beat transaction on the master
// request port. NOPs only advance the count, STOP ends the run early.
//
// Ports
//   clk, rst_n          : clock, synchronous active-low reset
//   start, abort        : run start pulse / stop-at-safe-point level
//   cmd_count           : commands in the run, sampled when start is accepted
//   cmd_rd_en/_addr     : command buffer read port, data returns 1 cycle later
//   cmd_rd_data         : command buffer read data
//   mst_req/_wr/_addr/_wdata : transaction request, held until mst_gnt
//   mst_gnt, mst_done, mst_rdata : request accepted / completed / read data
//   busy, done, aborted : run status (done is a one-cycle pulse)
//   exec_cnt            : commands completed in the current/last run
//   last_rdata          : data of the most recent completed read
//   dbg_state           : current FSM state
//
// Handshake: a request is presented with mst_req high and mst_wr/mst_addr/
// mst_wdata constant; it is consumed in the cycle mst_gnt is high, after which
// mst_req drops. Completion is the first cycle with mst_done high at or after
// the grant cycle (both may arrive together).
// -----------------------------------------------------------------------------
module gp_cmd_sequencer
  import gp_engine_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int BUF_AW     = 8,
  parameter int CNT_W      = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  abort,
  input  logic [CNT_W-1:0]      cmd_count,
  output logic                  cmd_rd_en,
  output logic [BUF_AW-1:0]     cmd_rd_addr,
  input  logic [ADDR_WIDTH-1:0] cmd_rd_data,
  output logic                  mst_req,
  output logic                  mst_wr,
  output logic [ADDR_WIDTH-1:0] mst_addr,
  output logic [ADDR_WIDTH-1:0] mst_wdata,
  input  logic                  mst_gnt,
  input  logic                  mst_done,
  input  logic [ADDR_WIDTH-1:0] mst_rdata,
  output logic                  busy,
  output logic                  done,
  output logic                  aborted,
  output logic [CNT_W-1:0]      exec_cnt,
  output logic [ADDR_WIDTH-1:0] last_rdata,
  output seq_state_e            dbg_state
);

  // Address-word pointer of the final command slot; the pointer stops here.
  localparam logic [BUF_AW-1:0] PTR_LAST = BUF_AW'(CMD_BUF_DEPTH - 2);

  seq_state_e            state_q, state_d;
  logic [BUF_AW-1:0]     ptr_q;
  logic [CNT_W-1:0]      count_q;
  logic [ADDR_WIDTH-1:0] addr_word_q;
  logic                  abort_pend_q;

  cmd_op_e op;
  logic    cmd_fin;     // a command completed this cycle
  logic    end_abort;   // run ends because of abort
  logic    abort_any;

  assign op        = cmd_op_e'(addr_word_q[1:0]);
  // An abort seen while a transaction is in flight is remembered so that the
  // run still stops even if abort is released before the transaction ends.
  assign abort_any = abort | abort_pend_q;
  assign dbg_state = state_q;

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d     = state_q;
    cmd_fin     = 1'b0;
    end_abort   = 1'b0;
    cmd_rd_en   = 1'b0;
    cmd_rd_addr = '0;
    unique case (state_q)
      S_IDLE: begin
        if (start) state_d = (cmd_count == '0) ? S_END : S_FETCH_A;
      end
      S_FETCH_A: begin
        cmd_rd_en   = 1'b1;
        cmd_rd_addr = ptr_q;
        if (abort) begin
          state_d   = S_END;
          end_abort = 1'b1;
        end else begin
          state_d = S_FETCH_D;
        end
      end
      S_FETCH_D: begin
        cmd_rd_en   = 1'b1;
        cmd_rd_addr = ptr_q + BUF_AW'(1);
        if (abort) begin
          state_d   = S_END;
          end_abort = 1'b1;
        end else begin
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        if (abort) begin
          state_d   = S_END;
          end_abort = 1'b1;
        end else begin
          case (op)
            OP_NOP: begin
              cmd_fin = 1'b1;
              state_d = S_NEXT;
            end
            OP_STOP:  state_d = S_END;
            default:  state_d = S_ISSUE;
          endcase
        end
      end
      S_ISSUE: begin
        if (mst_gnt) begin
          if (mst_done) begin
            cmd_fin = 1'b1;
            state_d = S_NEXT;
          end else begin
            state_d = S_WAIT_RSP;
          end
        end
      end
      S_WAIT_RSP: begin
        if (mst_done) begin
          cmd_fin = 1'b1;
          state_d = S_NEXT;
        end
      end
      S_NEXT: begin
        if (abort_any) begin
          state_d   = S_END;
          end_abort = 1'b1;
        end else if (exec_cnt == count_q || ptr_q == PTR_LAST) begin
          state_d = S_END;
        end else begin
          state_d = S_FETCH_A;
        end
      end
      S_END:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ptr_q        <= '0;
      count_q      <= '0;
      addr_word_q  <= '0;
      abort_pend_q <= 1'b0;
      mst_req      <= 1'b0;
      mst_wr       <= 1'b0;
      mst_addr     <= '0;
      mst_wdata    <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      aborted      <= 1'b0;
      exec_cnt     <= '0;
      last_rdata   <= '0;
    end else begin
      done <= 1'b0;

      if (state_q == S_IDLE && start) begin
        busy         <= 1'b1;
        exec_cnt     <= '0;
        ptr_q        <= '0;
        aborted      <= 1'b0;
        abort_pend_q <= 1'b0;
        count_q      <= cmd_count;
      end

      if (state_q == S_FETCH_D) addr_word_q <= cmd_rd_data;

      // The data word is on cmd_rd_data during DECODE; register it straight
      // into the request so the bus fields stay frozen while mst_req is high.
      if (state_q == S_DECODE && state_d == S_ISSUE) begin
        mst_req   <= 1'b1;
        mst_wr    <= (op == OP_WRITE);
        mst_addr  <= {addr_word_q[ADDR_WIDTH-1:2], 2'b00};
        mst_wdata <= cmd_rd_data;
      end

      if (state_q == S_ISSUE && mst_gnt) mst_req <= 1'b0;

      if ((state_q == S_ISSUE || state_q == S_WAIT_RSP) && abort)
        abort_pend_q <= 1'b1;

      if (cmd_fin) begin
        exec_cnt <= exec_cnt + CNT_W'(1);
        if (state_q != S_DECODE && !mst_wr) last_rdata <= mst_rdata;
      end

      if (state_q == S_NEXT && state_d == S_FETCH_A)
        ptr_q <= ptr_q + BUF_AW'(2);

      if (end_abort) aborted <= 1'b1;

      if (state_q == S_END) begin
        done         <= 1'b1;
        busy         <= 1'b0;
        abort_pend_q <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_gp_cmd_sequencer.sv
// -----------------------------------------------------------------------------
// tb_gp_cmd_sequencer
// Self-checking bench: command buffer model, bus slave with programmable grant
// and completion delays, expected-transaction queue, done/read-port monitors.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_gp_cmd_sequencer;
  import gp_engine_pkg::*;

  localparam int AW  = 32;
  localparam int BAW = 8;
  localparam int CW  = 8;

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int cycle = 0;
  always @(posedge clk) cycle++;

  // ---------------- DUT ----------------
  logic            start = 1'b0;
  logic            abort = 1'b0;
  logic [CW-1:0]   cmd_count = '0;
  logic            cmd_rd_en;
  logic [BAW-1:0]  cmd_rd_addr;
  logic [AW-1:0]   cmd_rd_data = '0;
  logic            mst_req, mst_wr;
  logic [AW-1:0]   mst_addr, mst_wdata;
  logic            mst_gnt = 1'b0;
  logic            mst_done = 1'b0;
  logic [AW-1:0]   mst_rdata = '0;
  logic            busy, done, aborted;
  logic [CW-1:0]   exec_cnt;
  logic [AW-1:0]   last_rdata;
  seq_state_e      dbg_state;

  gp_cmd_sequencer #(.ADDR_WIDTH(AW), .BUF_AW(BAW), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .cmd_count(cmd_count),
    .cmd_rd_en(cmd_rd_en), .cmd_rd_addr(cmd_rd_addr), .cmd_rd_data(cmd_rd_data),
    .mst_req(mst_req), .mst_wr(mst_wr), .mst_addr(mst_addr), .mst_wdata(mst_wdata),
    .mst_gnt(mst_gnt), .mst_done(mst_done), .mst_rdata(mst_rdata),
    .busy(busy), .done(done), .aborted(aborted),
    .exec_cnt(exec_cnt), .last_rdata(last_rdata), .dbg_state(dbg_state)
  );

  // ---------------- checking ----------------
  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ---------------- command buffer model (1-cycle read latency) ----------------
  logic [AW-1:0] cmd_mem [CMD_BUF_DEPTH];
  always @(posedge clk) if (cmd_rd_en) cmd_rd_data <= cmd_mem[cmd_rd_addr];

  // ---------------- scoreboard: expected {wr, addr, wdata} ----------------
  logic [64:0] exp_q[$];
  logic [64:0] sb_head;

  // ---------------- bus slave ----------------
  int            gnt_dly = 0;
  int            done_dly = 0;
  logic [AW-1:0] rd_value = '0;
  int            req_wait = 0;
  int            rsp_wait = -1;
  int            hold_cnt = 0;
  int            last_hold = 0;
  int            txn_cnt = 0;

  always @(negedge clk) begin
    mst_gnt  = 1'b0;
    mst_done = 1'b0;
    if (!rst_n) begin
      req_wait = 0;
      rsp_wait = -1;
      hold_cnt = 0;
    end else begin
      if (rsp_wait > 0) rsp_wait--;
      else if (rsp_wait == 0) begin
        mst_done  = 1'b1;
        mst_rdata = rd_value;
        rsp_wait  = -1;
      end
      if (mst_req) begin
        if (exp_q.size() != 0) begin
          sb_head = exp_q[0];
          check("mst_wr", 64'(mst_wr), 64'(sb_head[64]));
          check("mst_addr", 64'(mst_addr), 64'(sb_head[63:32]));
          if (sb_head[64]) check("mst_wdata", 64'(mst_wdata), 64'(sb_head[31:0]));
        end
        hold_cnt++;
        if (req_wait < gnt_dly) begin
          req_wait++;
        end else begin
          mst_gnt   = 1'b1;
          req_wait  = 0;
          last_hold = hold_cnt;
          hold_cnt  = 0;
          txn_cnt++;
          check("txn_expected", 64'(exp_q.size() != 0), 64'd1);
          if (exp_q.size() != 0) void'(exp_q.pop_front());
          if (done_dly == 0) begin
            mst_done  = 1'b1;
            mst_rdata = rd_value;
          end else begin
            rsp_wait = done_dly - 1;
          end
        end
      end
    end
  end

  // ---------------- monitors ----------------
  int done_cnt = 0;
  int done_cyc = 0;
  int rd_count = 0;
  int max_rd = 0;
  int prev_rd = 0;
  int rd_back = 0;
  bit have_prev = 1'b0;

  always @(negedge clk) begin
    if (done) begin
      done_cnt++;
      done_cyc = cycle;
    end
    if (cmd_rd_en) begin
      rd_count++;
      if (int'(cmd_rd_addr) > max_rd) max_rd = int'(cmd_rd_addr);
      if (have_prev && int'(cmd_rd_addr) < prev_rd) rd_back++;
      prev_rd   = int'(cmd_rd_addr);
      have_prev = 1'b1;
    end
  end

  // ---------------- driver tasks ----------------
  int start_cyc = 0;

  task automatic clear_stats();
    rd_count  = 0;
    max_rd    = 0;
    rd_back   = 0;
    have_prev = 1'b0;
  endtask

  task automatic pulse_start(input logic [CW-1:0] n);
    @(negedge clk);
    start     = 1'b1;
    cmd_count = n;
    start_cyc = cycle;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input int mark, input int budget);
    for (int i = 0; i < budget && done_cnt == mark; i++) begin
      @(negedge clk);
      #1;
    end
    check("done_seen", 64'(done_cnt != mark), 64'd1);
  endtask

  task automatic wait_cycles(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
    #1;
  endtask

  // ---------------- stimulus ----------------
  int mark;
  int txn_mark;
  int s5_start;

  initial begin
    for (int i = 0; i < CMD_BUF_DEPTH; i++) cmd_mem[i] = '0;

    // Reset values
    rst_n = 1'b0;
    wait_cycles(3);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_aborted", 64'(aborted), 64'd0);
    check("rst_exec_cnt", 64'(exec_cnt), 64'd0);
    check("rst_last_rdata", 64'(last_rdata), 64'd0);
    check("rst_mst_req", 64'(mst_req), 64'd0);
    check("rst_mst_addr", 64'(mst_addr), 64'd0);
    check("rst_rd_en", 64'(cmd_rd_en), 64'd0);
    check("rst_state", 64'(dbg_state), 64'(S_IDLE));
    @(negedge clk);
    rst_n = 1'b1;
    wait_cycles(2);

    // 1: empty run
    clear_stats();
    mark = done_cnt;
    pulse_start(8'd0);
    wait_done(mark, 20);
    check("t1_done_latency", 64'(done_cyc - start_cyc), 64'd2);
    check("t1_rd_count", 64'(rd_count), 64'd0);
    check("t1_exec_cnt", 64'(exec_cnt), 64'd0);
    check("t1_busy", 64'(busy), 64'd0);

    // 2: WRITE then READ, grant and completion together
    clear_stats();
    cmd_mem[0] = 32'h1000_0041;
    cmd_mem[1] = 32'hDEAD_BEEF;
    cmd_mem[2] = 32'h1000_0042;
    cmd_mem[3] = 32'h0000_0000;
    gnt_dly  = 0;
    done_dly = 0;
    rd_value = 32'h1234_5678;
    exp_q.push_back({1'b1, 32'h1000_0040, 32'hDEAD_BEEF});
    exp_q.push_back({1'b0, 32'h1000_0040, 32'h0000_0000});
    mark     = done_cnt;
    txn_mark = txn_cnt;
    pulse_start(8'd2);
    wait_done(mark, 100);
    wait_cycles(3);
    check("t2_last_rdata", 64'(last_rdata), 64'h1234_5678);
    check("t2_exec_cnt", 64'(exec_cnt), 64'd2);
    check("t2_done_count", 64'(done_cnt - mark), 64'd1);
    check("t2_txn_count", 64'(txn_cnt - txn_mark), 64'd2);
    check("t2_queue_empty", 64'(exp_q.size()), 64'd0);
    check("t2_rd_count", 64'(rd_count), 64'd4);
    check("t2_aborted", 64'(aborted), 64'd0);

    // 3: NOP, STOP, WRITE -> stops before the write
    clear_stats();
    cmd_mem[0] = 32'h2000_0010;
    cmd_mem[1] = 32'h1111_1111;
    cmd_mem[2] = 32'h2000_0013;
    cmd_mem[3] = 32'h2222_2222;
    cmd_mem[4] = 32'h2000_0015;
    cmd_mem[5] = 32'h3333_3333;
    mark     = done_cnt;
    txn_mark = txn_cnt;
    pulse_start(8'd3);
    wait_done(mark, 100);
    check("t3_done_latency", 64'(done_cyc - start_cyc), 64'd9);
    check("t3_txn_count", 64'(txn_cnt - txn_mark), 64'd0);
    check("t3_exec_cnt", 64'(exec_cnt), 64'd1);
    check("t3_rd_count", 64'(rd_count), 64'd4);
    check("t3_aborted", 64'(aborted), 64'd0);

    // 4: WRITE with slow grant, abort raised during ISSUE
    clear_stats();
    cmd_mem[0] = 32'h3000_0105;
    cmd_mem[1] = 32'hCAFE_F00D;
    cmd_mem[2] = 32'h3000_0201;
    cmd_mem[3] = 32'h4444_4444;
    gnt_dly  = 5;
    done_dly = 3;
    rd_value = 32'hBAD0_BAD0;
    exp_q.push_back({1'b1, 32'h3000_0104, 32'hCAFE_F00D});
    mark     = done_cnt;
    txn_mark = txn_cnt;
    pulse_start(8'd2);
    for (int i = 0; i < 30 && !mst_req; i++) begin
      @(negedge clk);
      #1;
    end
    check("t4_req_seen", 64'(mst_req), 64'd1);
    abort = 1'b1;
    wait_done(mark, 100);
    @(negedge clk);
    abort = 1'b0;
    wait_cycles(2);
    check("t4_req_hold", 64'(last_hold), 64'd6);
    check("t4_txn_count", 64'(txn_cnt - txn_mark), 64'd1);
    check("t4_exec_cnt", 64'(exec_cnt), 64'd1);
    check("t4_aborted", 64'(aborted), 64'd1);
    check("t4_queue_empty", 64'(exp_q.size()), 64'd0);
    check("t4_last_rdata_kept", 64'(last_rdata), 64'h1234_5678);

    // 5: 128 NOPs fill the whole buffer; a start mid-run is ignored
    clear_stats();
    for (int k = 0; k < CMD_BUF_DEPTH / 2; k++) begin
      cmd_mem[2*k]     = 32'(k) << 4;
      cmd_mem[2*k + 1] = 32'h5000_0000 + 32'(k);
    end
    mark     = done_cnt;
    txn_mark = txn_cnt;
    pulse_start(8'd128);
    s5_start = start_cyc;
    check("t5_aborted_cleared", 64'(aborted), 64'd0);
    wait_cycles(100);
    check("t5_busy_mid", 64'(busy), 64'd1);
    @(negedge clk);
    start     = 1'b1;
    cmd_count = 8'd1;
    @(negedge clk);
    start = 1'b0;
    wait_done(mark, 1000);
    check("t5_done_latency", 64'(done_cyc - s5_start), 64'd514);
    check("t5_max_rd_addr", 64'(max_rd), 64'd255);
    check("t5_rd_wrap", 64'(rd_back), 64'd0);
    check("t5_rd_count", 64'(rd_count), 64'd256);
    check("t5_exec_cnt", 64'(exec_cnt), 64'd128);
    wait_cycles(10);
    check("t5_done_count", 64'(done_cnt - mark), 64'd1);
    check("t5_idle_after", 64'(dbg_state), 64'(S_IDLE));
    check("t5_txn_count", 64'(txn_cnt - txn_mark), 64'd0);

    // 6: reset while waiting for completion
    clear_stats();
    cmd_mem[0] = 32'h4000_0009;
    cmd_mem[1] = 32'h55AA_55AA;
    gnt_dly  = 1;
    done_dly = 10;
    exp_q.push_back({1'b1, 32'h4000_0008, 32'h55AA_55AA});
    mark     = done_cnt;
    txn_mark = txn_cnt;
    pulse_start(8'd1);
    for (int i = 0; i < 30 && txn_cnt == txn_mark; i++) begin
      @(negedge clk);
      #1;
    end
    check("t6_granted", 64'(txn_cnt - txn_mark), 64'd1);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    #1;
    check("t6_busy", 64'(busy), 64'd0);
    check("t6_mst_req", 64'(mst_req), 64'd0);
    check("t6_exec_cnt", 64'(exec_cnt), 64'd0);
    check("t6_state", 64'(dbg_state), 64'(S_IDLE));
    @(negedge clk);
    rst_n = 1'b1;
    wait_cycles(15);
    check("t6_no_done", 64'(done_cnt - mark), 64'd0);
    check("t6_queue_empty", 64'(exp_q.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/gp_cmd_sequencer.md
Name: gp_cmd_sequencer

Overview:
Sequences the GP engine command buffer: on a start request from the register file, fetches command pairs from the 256-word command buffer and issues each as a single-beat bus transaction on the engine's master request port. Sits between the register file (control/status), the command buffer read port, and the AHB master front-end. Reports busy, completion and the last read data back to the register file.

Parameters:
ADDR_WIDTH, 32, width of issued transaction address and data
BUF_AW, 8, command buffer word-address width (256 entries)
CNT_W, 8, width of command-count field (max 128 commands = 256 words)

Ports:
clk  in  1  engine clock
rst_n  in  1  synchronous active-low reset
start  in  1  one-cycle pulse from register file; begins a run
abort  in  1  level; stops the run at the next safe point
cmd_count  in  CNT_W  number of commands in the run (0..128); sampled on accepted start
cmd_rd_en  out  1  command buffer read strobe
cmd_rd_addr  out  BUF_AW  command buffer word offset
cmd_rd_data  in  ADDR_WIDTH  read data, valid exactly 1 cycle after cmd_rd_en
mst_req  out  1  transaction request, held until mst_gnt
mst_wr  out  1  1 = write, 0 = read
mst_addr  out  ADDR_WIDTH  word-aligned target address ([1:0] = 0)
mst_wdata  out  ADDR_WIDTH  write data
mst_gnt  in  1  request accepted this cycle
mst_done  in  1  transaction completed (write ack or read data valid)
mst_rdata  in  ADDR_WIDTH  read data, valid with mst_done on reads
busy  out  1  run in progress
done  out  1  one-cycle pulse at run end
aborted  out  1  sticky: last run ended by abort; cleared on next accepted start
exec_cnt  out  CNT_W  commands completed in current/last run
last_rdata  out  ADDR_WIDTH  data of most recent completed read

Behaviour:
- Reset: all outputs 0; state IDLE; pointer 0.
- Command format: two consecutive entries 2k (address word) and 2k+1 (data word). Opcode in address word [1:0]: 00 NOP, 01 WRITE, 10 READ, 11 STOP. mst_addr = {addr_word[31:2], 2'b00}.
- States: IDLE -> FETCH_A (rd_en, addr=ptr) -> FETCH_D (capture addr word; rd_en, addr=ptr+1) -> DECODE (capture data word) -> ISSUE (mst_req high until mst_gnt) -> WAIT_RSP (until mst_done) -> next or END.
- IDLE: start accepted only in IDLE; start while busy ignored. On accept: busy=1, exec_cnt=0, ptr=0, aborted=0. cmd_count=0 -> END directly (done pulses 2 cycles after start, no buffer read).
- DECODE: NOP -> exec_cnt+1, no bus activity. STOP -> END without incrementing exec_cnt. WRITE/READ -> ISSUE; mst_* registered, stable while mst_req high.
- WAIT_RSP on mst_done: exec_cnt+1; READ loads last_rdata. mst_gnt and mst_done in same cycle: ISSUE goes straight to next command.
- Next command: ptr += 2; if exec_cnt == cmd_count -> END, else FETCH_A. ptr never wraps; 128 commands end at ptr 254.
- END: done=1 one cycle, busy=0 same cycle, -> IDLE.
- Abort: in FETCH_A/FETCH_D/DECODE -> END next cycle, aborted=1. In ISSUE/WAIT_RSP: current transaction completes (req held to gnt, wait done), counted, then END with aborted=1. Abort in IDLE ignored.
- Throughput: minimum 4 cycles per NOP, 5 + gnt/done latency per bus command.
- rst_n low mid-run: all state returns to reset values next edge; no done pulse.

Decomposition:
- Package gp_engine_pkg: cmd_op_e enum (OP_NOP, OP_WRITE, OP_READ, OP_STOP), seq_state_e enum, CMD_BUF_DEPTH=256 constant.
- Single module; no sub-module (counter and FSM inline).

Test Plan:
- cmd_count=0, start -> no cmd_rd_en, done pulse 2 cycles after start, exec_cnt=0.
- 2 cmds: WRITE 0x1000_0041/0xDEAD_BEEF, READ 0x1000_0042; slave returns 0x1234_5678 -> mst_addr 0x1000_0040 wr=1 wdata DEADBEEF, then read of 0x1000_0040; last_rdata=0x12345678, exec_cnt=2, one done.
- cmds NOP, STOP, WRITE with cmd_count=3 -> no bus request, exec_cnt=1, done, aborted=0.
- WRITE with mst_gnt delayed 5 cycles; abort raised during ISSUE -> mst_req/addr/wdata stable 6 cycles, write completes, exec_cnt=1, aborted=1.
- 128 NOPs -> cmd_rd_addr reaches 255, never wraps, exec_cnt=128, done; start pulsed mid-run ignored.
- rst_n low during WAIT_RSP -> next cycle busy=0, mst_req=0, exec_cnt=0, no done pulse.
